debounce_edge_meter: RTL
========================

# debounce_edge_meter

Downstream consumer of the one-cycle input register stage. It takes the registered single-bit signal, debounces it with a programmable stability window, emits one-cycle rise and fall strobes, counts accepted rising edges and measures the width of each accepted high pulse. All logic runs on one clock, so glitches removed here never reach the control logic further downstream.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a level change; legal range 1..255.
- CNT_W, 8: width of `pulse_cnt` and `last_width`; legal range 2..32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  registered input bit from the upstream register stage.
- clr  in  1  synchronous clear of `pulse_cnt` and `last_width`; does not affect debounce state.
- sig_clean  out  1  debounced level.
- rise_pulse  out  1  one-cycle strobe on an accepted 0->1 change.
- fall_pulse  out  1  one-cycle strobe on an accepted 1->0 change.
- pulse_cnt  out  CNT_W  count of accepted rising edges; saturates at 2^CNT_W-1.
- last_width  out  CNT_W  high width of the last accepted pulse, in clk cycles; saturates.
- width_valid  out  1  one-cycle strobe; `last_width` was updated on this edge.

## Operation
- The FSM has four states.
  - LOW: `sig_clean`=0.
  - CHK_H: a rise candidate is being checked.
  - HIGH: `sig_clean`=1.
  - CHK_L: a fall candidate is being checked.
- `stab` counter: 8 bits, counts consecutive candidate samples.
- LOW behaviour:
  - `sig_in`=1 -> `stab`=1.
  - If STABLE_CYCLES==1, go straight to HIGH (accept on the same edge); otherwise go to CHK_H.
- CHK_H behaviour:
  - `sig_in`=0 -> return to LOW, no strobe.
  - Else increment `stab`; when the incremented value == STABLE_CYCLES -> accept and go to HIGH.
- HIGH and CHK_L mirror LOW and CHK_H with the polarity inverted.
- Accept rise, all in the same registered edge:
  - `sig_clean`<=1.
  - `rise_pulse`<=1.
  - `pulse_cnt` increments (saturating).
  - width counter `wcnt`<=1.
- While `sig_clean`=1 and no fall is accepted: `wcnt` increments each edge, saturating at 2^CNT_W-1.
- Accept fall, all in the same registered edge:
  - `sig_clean`<=0.
  - `fall_pulse`<=1.
  - `last_width`<=`wcnt`.
  - `width_valid`<=1.
- Arithmetic: the saturating increment holds at all-ones and never wraps to 0.

## Timing
- Reset values:
  - state=LOW, `stab`=0, `wcnt`=0.
  - `sig_clean`=0, `rise_pulse`=0, `fall_pulse`=0.
  - `pulse_cnt`=0, `last_width`=0, `width_valid`=0.
- Latency:
  - If `sig_in` is 1 on edges N..N+S-1 (S=STABLE_CYCLES), `sig_clean` and `rise_pulse` are 1 after edge N+S-1.
  - The fall path has the same latency.
  - Therefore `sig_clean` reproduces a clean input pulse of H cycles as exactly H cycles high, delayed by S-1 edges, and `last_width`=H.
- Glitch rejection: any run shorter than S samples produces no output change and no strobe.
- Strobes are registered and high for exactly one cycle. `rise_pulse` and `fall_pulse` are never high together.
- `clr` priority over increment or capture on the same edge:
  - `pulse_cnt`<=0 and `last_width`<=0.
  - `width_valid` is suppressed on that edge.
  - `sig_clean`, `rise_pulse`, `fall_pulse` and `wcnt` behave normally.
- `rst` priority over everything, including `clr`. Reset mid-pulse drops `sig_clean` to 0 without a `fall_pulse`.
- No handshake: all outputs are registered and valid every cycle.

## Test plan
- Reset and glitch rejection:
  - Stimulus: S=4, `rst` high 2 cycles; then `sig_in`=1 for 3 cycles, then 0.
  - Required: all outputs 0 throughout; `pulse_cnt`=0.
- Clean pulse:
  - Stimulus: `sig_in` 0->1 at edge 10, held 12 cycles, then 0.
  - Required: `rise_pulse` after edge 13; `fall_pulse` and `width_valid` after edge 25; `last_width`=12; `pulse_cnt`=1.
- S=1 build:
  - Stimulus: a single-cycle `sig_in` pulse.
  - Required: `sig_clean` high exactly 1 cycle, one edge later; `last_width`=1.
- Counter saturation:
  - Stimulus: CNT_W=2; 5 accepted pulses, the last held 6 cycles.
  - Required: `pulse_cnt`=3; `last_width`=3.
- `clr` collisions:
  - Stimulus 1: assert `clr` on the edge a fall is accepted.
  - Required: `last_width`=0, `width_valid`=0, `fall_pulse`=1.
  - Stimulus 2: assert `clr` on the edge a rise is accepted.
  - Required: `pulse_cnt`=0.
- Reset mid-pulse:
  - Stimulus: `rst` while `sig_clean`=1.
  - Required: next cycle `sig_clean`=0 with no `fall_pulse`; a following pulse re-accepts normally.

Source files
------------

// File: rtl/debounce_edge_meter.sv
// Debounces a registered single-bit input, emits rise/fall strobes,
// counts accepted rising edges and measures the width of each accepted high pulse.
module debounce_edge_meter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic             sig_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] last_width,
    output logic             width_valid
);

    localparam logic [1:0] LOW   = 2'd0;
    localparam logic [1:0] CHK_H = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;
    localparam logic [1:0] CHK_L = 2'd3;

    localparam logic [7:0]       STAB_TARGET = 8'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [7:0]       stab;
    logic [7:0]       stab_next;
    logic [7:0]       stab_inc;
    logic             accept_rise;
    logic             accept_fall;
    logic [CNT_W-1:0] wcnt;

    assign stab_inc = stab + 8'd1;

    // A candidate level must be seen STABLE_CYCLES times in a row before it is accepted.
    always_comb begin
        state_next  = state;
        stab_next   = stab;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        case (state)
            LOW: begin
                if (sig_in) begin
                    stab_next = 8'd1;
                    if (STABLE_CYCLES == 1) begin
                        accept_rise = 1'b1;
                        state_next  = HIGH;
                    end else begin
                        state_next = CHK_H;
                    end
                end
            end
            CHK_H: begin
                if (!sig_in) begin
                    stab_next  = 8'd0;
                    state_next = LOW;
                end else begin
                    stab_next = stab_inc;
                    if (stab_inc == STAB_TARGET) begin
                        accept_rise = 1'b1;
                        state_next  = HIGH;
                    end
                end
            end
            HIGH: begin
                if (!sig_in) begin
                    stab_next = 8'd1;
                    if (STABLE_CYCLES == 1) begin
                        accept_fall = 1'b1;
                        state_next  = LOW;
                    end else begin
                        state_next = CHK_L;
                    end
                end
            end
            CHK_L: begin
                if (sig_in) begin
                    stab_next  = 8'd0;
                    state_next = HIGH;
                end else begin
                    stab_next = stab_inc;
                    if (stab_inc == STAB_TARGET) begin
                        accept_fall = 1'b1;
                        state_next  = LOW;
                    end
                end
            end
            default: state_next = LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOW;
            stab        <= 8'd0;
            wcnt        <= '0;
            sig_clean   <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            pulse_cnt   <= '0;
            last_width  <= '0;
            width_valid <= 1'b0;
        end else begin
            state       <= state_next;
            stab        <= stab_next;
            rise_pulse  <= accept_rise;
            fall_pulse  <= accept_fall;
            width_valid <= accept_fall && !clr;

            if (accept_rise) begin
                sig_clean <= 1'b1;
            end else if (accept_fall) begin
                sig_clean <= 1'b0;
            end

            if (accept_rise) begin
                wcnt <= CNT_ONE;
            end else if (sig_clean && !accept_fall && wcnt != CNT_MAX) begin
                wcnt <= wcnt + CNT_ONE;
            end

            // Clear wins over both the edge count and the width capture.
            if (clr) begin
                pulse_cnt  <= '0;
                last_width <= '0;
            end else begin
                if (accept_rise && pulse_cnt != CNT_MAX) begin
                    pulse_cnt <= pulse_cnt + CNT_ONE;
                end
                if (accept_fall) begin
                    last_width <= wcnt;
                end
            end
        end
    end

endmodule
